// File: rtl/gs_conv5x5_engine.sv
// gs_conv5x5_engine: raster-scans a stored frame and streams 5x5 Gaussian-filtered pixels
module gs_conv5x5_engine #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int CRD_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [CRD_W-1:0]  pix_x,
  output logic [CRD_W-1:0]  pix_y,
  output logic [7:0]        pix_out
);
  typedef enum logic [2:0] {IDLE, RD, DRAIN, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [CRD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0] ti_q, ti_d, tj_q, tj_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0] wgt_q, wgt_d;
  logic last_tap, last_pix, accept, launch;
  logic signed [31:0] cx, cy;

  function automatic logic [7:0] kw(input logic [2:0] n);
    return (n == 3'd0 || n == 3'd4) ? 8'd1 : (n == 3'd2) ? 8'd6 : 8'd4;
  endfunction

  assign last_tap = ti_q == 3'd4 && tj_q == 3'd4;
  assign last_pix = x_q == CRD_W'(IMG_W - 1) && y_q == CRD_W'(IMG_H - 1);
  assign accept   = state_q == OUT && pix_ready;
  assign launch   = state_q == IDLE && start;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RD : IDLE;
      RD:      state_d = last_tap ? DRAIN : RD;
      DRAIN:   state_d = OUT;
      OUT:     state_d = !pix_ready ? OUT : last_pix ? DONE : RD;
      default: state_d = IDLE;
    endcase
  end

  // datapath registers: raster position, tap counters, weight pipeline and accumulator
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      ti_q  <= '0;
      tj_q  <= '0;
      acc_q <= '0;
      wgt_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      ti_q  <= ti_d;
      tj_q  <= tj_d;
      acc_q <= acc_d;
      wgt_q <= wgt_d;
    end

  // datapath next state; weight of a tap lines up with its read data one cycle later
  always_comb begin
    x_d   = launch ? '0 : x_q;
    y_d   = launch ? '0 : y_q;
    tj_d  = state_q == RD ? (tj_q == 3'd4 ? 3'd0 : tj_q + 3'd1) : tj_q;
    ti_d  = state_q == RD ? (last_tap ? 3'd0 : tj_q == 3'd4 ? ti_q + 3'd1 : ti_q) : ti_q;
    if (accept && !last_pix) begin
      x_d = x_q == CRD_W'(IMG_W - 1) ? '0 : x_q + 1'b1;
      y_d = x_q == CRD_W'(IMG_W - 1) ? y_q + 1'b1 : y_q;
    end
    wgt_d = rd_en ? kw(ti_q) * kw(tj_q) : 8'd0;
    acc_d = (launch || accept) ? 16'd0 : rd_valid ? acc_q + 16'(rd_data) * 16'(wgt_q) : acc_q;
  end

  // outputs decoded from state; edge-replicated tap address, zero outside reads
  always_comb begin
    rd_en     = state_q == RD;
    busy      = state_q != IDLE && state_q != DONE;
    done      = state_q == DONE;
    pix_valid = state_q == OUT;
    cx        = 32'(x_q) + 32'(tj_q) - 2;
    cy        = 32'(y_q) + 32'(ti_q) - 2;
    cx        = cx < 0 ? 0 : cx > IMG_W - 1 ? IMG_W - 1 : cx;
    cy        = cy < 0 ? 0 : cy > IMG_H - 1 ? IMG_H - 1 : cy;
    rd_addr   = rd_en ? ADDR_W'(cy * IMG_W + cx) : '0;
    pix_x     = pix_valid ? x_q : '0;
    pix_y     = pix_valid ? y_q : '0;
    pix_out   = pix_valid ? 8'((acc_q + 16'd128) >> 8) : 8'd0;
  end
endmodule

// File: tb/tb_gs_conv5x5_engine.sv
// tb_gs_conv5x5_engine: scoreboard bench for the 5x5 Gaussian engine on 8x4 and 16x16 frames
module tb_gs_conv5x5_engine;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;

  logic st8 = 0, bz8, dn8, re8, rv8, pv8, pr8 = 1;
  logic [15:0] ra8;
  logic [7:0] rdd8, px8, py8, po8;
  logic st16 = 0, bz16, dn16, re16, rv16, pv16, pr16 = 1;
  logic [15:0] ra16;
  logic [7:0] rdd16, px16, py16, po16;

  logic [7:0] mem8 [32];
  logic [7:0] mem16 [256];
  logic [7:0] got16 [256];
  logic [23:0] q8 [$];
  logic [23:0] q16 [$];
  logic [23:0] exp8, exp16;

  gs_conv5x5_engine #(.IMG_W(8), .IMG_H(4), .ADDR_W(16), .CRD_W(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .busy(bz8), .done(dn8), .rd_en(re8), .rd_addr(ra8),
    .rd_data(rdd8), .rd_valid(rv8), .pix_valid(pv8), .pix_ready(pr8), .pix_x(px8), .pix_y(py8),
    .pix_out(po8));

  gs_conv5x5_engine #(.IMG_W(16), .IMG_H(16), .ADDR_W(16), .CRD_W(8)) u16 (
    .clk(clk), .rst(rst), .start(st16), .busy(bz16), .done(dn16), .rd_en(re16), .rd_addr(ra16),
    .rd_data(rdd16), .rd_valid(rv16), .pix_valid(pv16), .pix_ready(pr16), .pix_x(px16), .pix_y(py16),
    .pix_out(po16));

  always @(posedge clk) begin
    rv8   <= re8;
    rdd8  <= mem8[ra8[4:0]];
    rv16  <= re16;
    rdd16 <= mem16[ra16[7:0]];
  end

  always @(negedge clk)
    if (!rst && pv8 && pr8) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL sb8 unexpected pixel (%0d,%0d)=%0d", px8, py8, po8);
      end else begin
        exp8 = q8.pop_front();
        if ({px8, py8, po8} !== exp8) begin
          failures++;
          $display("FAIL sb8 got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                   px8, py8, po8, exp8[23:16], exp8[15:8], exp8[7:0]);
        end
      end
    end

  always @(negedge clk)
    if (!rst && pv16 && pr16) begin
      checks++;
      got16[{py16[3:0], px16[3:0]}] = po16;
      if (q16.size() == 0) begin
        failures++;
        $display("FAIL sb16 unexpected pixel (%0d,%0d)=%0d", px16, py16, po16);
      end else begin
        exp16 = q16.pop_front();
        if ({px16, py16, po16} !== exp16) begin
          failures++;
          $display("FAIL sb16 got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                   px16, py16, po16, exp16[23:16], exp16[15:8], exp16[7:0]);
        end
      end
    end

  function automatic int kval(input int n);
    return (n == 0 || n == 4) ? 1 : (n == 2) ? 6 : 4;
  endfunction

  function automatic logic [7:0] ref_pix(input bit big, input int x, input int y);
    int w, h, cx, cy, s;
    w = big ? 16 : 8;
    h = big ? 16 : 4;
    s = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        cy = y + i - 2;
        cx = x + j - 2;
        if (cy < 0) cy = 0;
        if (cy > h - 1) cy = h - 1;
        if (cx < 0) cx = 0;
        if (cx > w - 1) cx = w - 1;
        s += kval(i) * kval(j) * int'(big ? mem16[cy * w + cx] : mem8[cy * w + cx]);
      end
    return 8'((s + 128) / 256);
  endfunction

  task automatic push_frame(input bit big);
    for (int y = 0; y < (big ? 16 : 4); y++)
      for (int x = 0; x < (big ? 16 : 8); x++)
        if (big) q16.push_back({8'(x), 8'(y), ref_pix(1'b1, x, y)});
        else     q8.push_back({8'(x), 8'(y), ref_pix(1'b0, x, y)});
  endtask

  task automatic pulse8();
    @(posedge clk); #1 st8 = 1;
    @(posedge clk); #1 st8 = 0;
  endtask

  task automatic pulse16();
    @(posedge clk); #1 st16 = 1;
    @(posedge clk); #1 st16 = 0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!dn8 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_done16(output int cyc);
    cyc = 0;
    while (!dn16 && cyc < 9000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1;
    #2;
    checks++;
    if ({bz8, dn8, re8, ra8, pv8, px8, py8, po8} !== '0) begin
      failures++;
      $display("FAIL reset8 outputs=%h required 0", {bz8, dn8, re8, ra8, pv8, px8, py8, po8});
    end
    checks++;
    if ({bz16, dn16, re16, ra16, pv16, px16, py16, po16} !== '0) begin
      failures++;
      $display("FAIL reset16 outputs=%h required 0", {bz16, dn16, re16, ra16, pv16, px16, py16, po16});
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_const_addr();
    int cyc, run, bad, extra;
    bit in_run;
    logic [15:0] addrs [25];
    int ea [25] = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 8, 8, 8, 9, 10, 16, 16, 16, 17, 18};
    foreach (mem8[i]) mem8[i] = 8'd100;
    push_frame(1'b0);
    pulse8();
    checks++;
    if (bz8 !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got=%b required 1", bz8);
    end
    cyc = 0; run = 0; in_run = 1;
    while (!dn8 && cyc < 3000) begin
      if (in_run) begin
        if (re8) begin
          if (run < 25) addrs[run] = ra8;
          run++;
        end else in_run = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (run != 25) begin
      failures++;
      $display("FAIL rd_en_run got=%0d required 25", run);
    end
    bad = 0;
    for (int k = 0; k < 25; k++)
      if (run >= 25 && addrs[k] !== 16'(ea[k])) bad++;
    checks++;
    if (bad != 0 || run < 25) begin
      failures++;
      $display("FAIL addr_seq mismatching=%0d run=%0d required 0 and 25", bad, run);
    end
    checks++;
    if (cyc >= 3000) begin
      failures++;
      $display("FAIL const_done got=timeout required done");
    end
    @(posedge clk); #1;
    checks++;
    if ({dn8, bz8} !== 2'b00) begin
      failures++;
      $display("FAIL after_done done,busy=%b required 00", {dn8, bz8});
    end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (dn8 || bz8) extra++;
    end
    checks++;
    if (extra != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL const_tail extra=%0d left=%0d required 0 and 0", extra, q8.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit stable;
    logic [23:0] held;
    foreach (mem8[i]) mem8[i] = 8'($urandom);
    push_frame(1'b0);
    pulse8();
    cyc = 0;
    while (!(pv8 && px8 == 8'd3 && py8 == 8'd1) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    pr8 = 0;
    checks++;
    if (cyc >= 2000) begin
      failures++;
      $display("FAIL bp_reach got=timeout required pixel (3,1)");
    end
    held = {px8, py8, po8};
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      st8 = (k == 3);
      if (!(pv8 === 1'b1 && re8 === 1'b0 && {px8, py8, po8} === held)) stable = 0;
    end
    st8 = 0;
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold got pv=%b re=%b pix=%h required 1 0 %h", pv8, re8, {px8, py8, po8}, held);
    end
    pr8 = 1;
    @(posedge clk); #1;
    checks++;
    if ({re8, ra8} !== {1'b1, 16'd2}) begin
      failures++;
      $display("FAIL bp_resume rd_en,addr=%b,%0d required 1,2", re8, ra8);
    end
    wait_done8(cyc);
    checks++;
    if (cyc >= 3000 || q8.size() != 0) begin
      failures++;
      $display("FAIL bp_done cycles=%0d left=%0d required done and 0", cyc, q8.size());
    end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    foreach (mem8[i]) mem8[i] = 8'($urandom);
    push_frame(1'b0);
    pulse8();
    cyc = 0;
    while (!(pv8 && px8 == 8'd1 && py8 == 8'd1) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (13) @(posedge clk);
    #1;
    checks++;
    if ({re8, ra8} !== {1'b1, 16'd10}) begin
      failures++;
      $display("FAIL mid_tap12 rd_en,addr=%b,%0d required 1,10", re8, ra8);
    end
    rst = 1;
    #1;
    checks++;
    if ({bz8, dn8, re8, ra8, pv8, px8, py8, po8} !== '0) begin
      failures++;
      $display("FAIL mid_reset outputs=%h required 0", {bz8, dn8, re8, ra8, pv8, px8, py8, po8});
    end
    @(posedge clk); #1 rst = 0;
    q8.delete();
    push_frame(1'b0);
    pulse8();
    wait_done8(cyc);
    checks++;
    if (cyc >= 3000 || q8.size() != 0) begin
      failures++;
      $display("FAIL restart_done cycles=%0d left=%0d required done and 0", cyc, q8.size());
    end
  endtask

  task automatic test_impulse();
    int cyc, bad;
    foreach (mem16[i]) mem16[i] = 8'd0;
    foreach (got16[i]) got16[i] = 8'hAA;
    mem16[8 * 16 + 8] = 8'd255;
    push_frame(1'b1);
    pulse16();
    wait_done16(cyc);
    checks++;
    if (cyc >= 9000 || q16.size() != 0) begin
      failures++;
      $display("FAIL imp_done cycles=%0d left=%0d required done and 0", cyc, q16.size());
    end
    checks++;
    if ({got16[136], got16[135], got16[134], got16[102]} !== {8'd36, 8'd24, 8'd6, 8'd1}) begin
      failures++;
      $display("FAIL imp_values got=%0d,%0d,%0d,%0d required 36,24,6,1",
               got16[136], got16[135], got16[134], got16[102]);
    end
    bad = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if ((x < 6 || x > 10 || y < 6 || y > 10) && got16[y * 16 + x] !== 8'd0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL imp_far nonzero=%0d required 0", bad);
    end
  endtask

  task automatic test_corner();
    int cyc;
    foreach (mem16[i]) mem16[i] = 8'd0;
    foreach (got16[i]) got16[i] = 8'hAA;
    mem16[0] = 8'd255;
    push_frame(1'b1);
    pulse16();
    wait_done16(cyc);
    checks++;
    if (cyc >= 9000 || q16.size() != 0) begin
      failures++;
      $display("FAIL corner_done cycles=%0d left=%0d required done and 0", cyc, q16.size());
    end
    checks++;
    if ({got16[0], got16[1]} !== {8'd121, 8'd55}) begin
      failures++;
      $display("FAIL corner_values got=%0d,%0d required 121,55", got16[0], got16[1]);
    end
  endtask

  initial begin
    test_reset();
    test_const_addr();
    test_backpressure();
    test_reset_midframe();
    test_impulse();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
